// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, shift-add multiplier and the EX/MEM register.
// ex_busy stalls upstream while a multiply iterates; bubbles go to MEM during the stall.
module ex_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rd1_in,
    input  logic [WIDTH-1:0] rd2_in,
    input  logic [WIDTH-1:0] imm_in,
    input  logic [4:0]       rs_in,
    input  logic [4:0]       rt_in,
    input  logic [4:0]       rd_in,
    input  logic             RegWrite_in,
    input  logic             MemRead_in,
    input  logic             MemWrite_in,
    input  logic             MemToReg_in,
    input  logic             ALUSrc_in,
    input  logic [1:0]       ALUOp_in,
    input  logic             flush,
    input  logic             wb_RegWrite,
    input  logic [4:0]       wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] wdata_out,
    output logic [4:0]       dst_out,
    output logic             RegWrite_out,
    output logic             MemRead_out,
    output logic             MemWrite_out,
    output logic             MemToReg_out,
    output logic             zero_out,
    output logic             ex_busy
);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [5:0]       count_q, count_d;

    logic [WIDTH-1:0] op_a, fwd_b, op_b, result;
    logic [5:0]       funct;
    logic [4:0]       shamt;
    logic             is_mul;

    assign funct  = imm_in[5:0];
    assign shamt  = imm_in[10:6];
    assign is_mul = (ALUOp_in == 2'b10) && (funct == 6'h18) && RegWrite_in;

    // Loads in EX/MEM (MemToReg) have no data yet, so only ALU results forward from there.
    always_comb begin
        if (RegWrite_out && !MemToReg_out && dst_out != 5'd0 && dst_out == rs_in) begin
            op_a = alu_out;
        end else if (wb_RegWrite && wb_rd != 5'd0 && wb_rd == rs_in) begin
            op_a = wb_data;
        end else begin
            op_a = rd1_in;
        end
        if (RegWrite_out && !MemToReg_out && dst_out != 5'd0 && dst_out == rt_in) begin
            fwd_b = alu_out;
        end else if (wb_RegWrite && wb_rd != 5'd0 && wb_rd == rt_in) begin
            fwd_b = wb_data;
        end else begin
            fwd_b = rd2_in;
        end
        op_b = ALUSrc_in ? imm_in : fwd_b;
    end

    always_comb begin
        result = '0;
        case (ALUOp_in)
            2'b01: result = op_a - op_b;
            2'b10: begin
                case (funct)
                    6'h20:   result = op_a + op_b;
                    6'h22:   result = op_a - op_b;
                    6'h24:   result = op_a & op_b;
                    6'h25:   result = op_a | op_b;
                    6'h2A:   result = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                    6'h00:   result = op_b << shamt;
                    6'h02:   result = op_b >> shamt;
                    default: result = '0;
                endcase
            end
            default: result = op_a + op_b;
        endcase
        if (state_q == StDone) begin
            result = acc_q;
        end
    end

    // Operands are captured at start: the writeback bus may move on during the stall.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        count_d = count_q;
        ex_busy = 1'b0;
        case (state_q)
            StIdle: begin
                if (is_mul && !flush) begin
                    ex_busy = 1'b1;
                    mcand_d = op_a;
                    mplr_d  = op_b;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = StMul;
                end
            end
            StMul: begin
                ex_busy = 1'b1;
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    if (mplr_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d = mcand_q << 1;
                    mplr_d  = mplr_q >> 1;
                    count_d = count_q + 6'd1;
                    if (count_q == 6'd31) begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || ex_busy || flush) begin
            alu_out      <= '0;
            wdata_out    <= '0;
            dst_out      <= '0;
            RegWrite_out <= 1'b0;
            MemRead_out  <= 1'b0;
            MemWrite_out <= 1'b0;
            MemToReg_out <= 1'b0;
            zero_out     <= 1'b0;
        end else begin
            alu_out      <= result;
            wdata_out    <= fwd_b;
            dst_out      <= (ALUOp_in == 2'b10) ? rd_in : rt_in;
            RegWrite_out <= RegWrite_in;
            MemRead_out  <= MemRead_in;
            MemWrite_out <= MemWrite_in;
            MemToReg_out <= MemToReg_in;
            zero_out     <= (result == '0);
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases with literal expectations, then random
// traffic against a cycle-level reference model of forwarding, ALU and multiply latency.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] rd1_in = '0, rd2_in = '0, imm_in = '0;
    logic [4:0]  rs_in = '0, rt_in = '0, rd_in = '0;
    logic        RegWrite_in = 0, MemRead_in = 0, MemWrite_in = 0, MemToReg_in = 0, ALUSrc_in = 0;
    logic [1:0]  ALUOp_in = '0;
    logic        flush = 1'b0;
    logic        wb_RegWrite = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] alu_out, wdata_out;
    logic [4:0]  dst_out;
    logic        RegWrite_out, MemRead_out, MemWrite_out, MemToReg_out, zero_out, ex_busy;

    always #5 clk = ~clk;

    ex_stage #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
        .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .MemToReg_in(MemToReg_in), .ALUSrc_in(ALUSrc_in), .ALUOp_in(ALUOp_in),
        .flush(flush), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .alu_out(alu_out), .wdata_out(wdata_out), .dst_out(dst_out),
        .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
        .MemToReg_out(MemToReg_out), .zero_out(zero_out), .ex_busy(ex_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: expected EX/MEM contents and cycles elapsed since a multiply started.
    logic [31:0] m_alu = '0, m_wdata = '0, m_prod = '0;
    logic [4:0]  m_dst = '0;
    logic        m_rw = 0, m_mr = 0, m_mw = 0, m_m2r = 0, m_zero = 0;
    int          m_phase = 0;
    logic        m_busy = 1'b0;
    logic        dut_busy = 1'b0;

    logic [5:0] functs [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h3F};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] dflt);
        if (m_rw && !m_m2r && m_dst != 5'd0 && m_dst == r) return m_alu;
        if (wb_RegWrite && wb_rd != 5'd0 && wb_rd == r) return wb_data;
        return dflt;
    endfunction

    function automatic logic [31:0] alu_model(input logic [1:0] op, input logic [31:0] imm,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [5:0] f;
        int         sh;
        f  = imm[5:0];
        sh = int'(imm[10:6]);
        if (op == 2'b01) return a - b;
        if (op != 2'b10) return a + b;
        case (f)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h00:   return b << sh;
            6'h02:   return b >> sh;
            default: return 32'd0;
        endcase
    endfunction

    // One clock: check ex_busy against the model, clock, then check every registered output.
    task automatic step();
        logic [31:0] fa, fb, b, res;
        logic        is_mul, bubble;
        int          nphase;
        #1;
        fa     = fwd(rs_in, rd1_in);
        fb     = fwd(rt_in, rd2_in);
        b      = ALUSrc_in ? imm_in : fb;
        is_mul = (ALUOp_in == 2'b10) && (imm_in[5:0] == 6'h18) && RegWrite_in;
        m_busy = (m_phase == 0) ? (is_mul && !flush) : (m_phase <= 32);
        dut_busy = ex_busy;
        chk("ex_busy", 32'(ex_busy), 32'(m_busy));
        res    = (m_phase == 33) ? m_prod : alu_model(ALUOp_in, imm_in, fa, b);
        bubble = m_busy || flush;
        nphase = 0;
        if (!reset) begin
            if (m_phase == 0) begin
                if (m_busy) begin
                    nphase = 1;
                    m_prod = fa * b;
                end
            end else if (m_phase <= 32) begin
                nphase = flush ? 0 : m_phase + 1;
            end
        end
        @(posedge clk);
        #1;
        m_phase = nphase;
        if (reset || bubble) begin
            m_alu = '0; m_wdata = '0; m_dst = '0;
            m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_zero = 0;
        end else begin
            m_alu = res; m_wdata = fb;
            m_dst = (ALUOp_in == 2'b10) ? rd_in : rt_in;
            m_rw = RegWrite_in; m_mr = MemRead_in; m_mw = MemWrite_in; m_m2r = MemToReg_in;
            m_zero = (res == 32'd0);
        end
        chk("alu_out", alu_out, m_alu);
        chk("wdata_out", wdata_out, m_wdata);
        chk("dst_out", 32'(dst_out), 32'(m_dst));
        chk("RegWrite_out", 32'(RegWrite_out), 32'(m_rw));
        chk("MemRead_out", 32'(MemRead_out), 32'(m_mr));
        chk("MemWrite_out", 32'(MemWrite_out), 32'(m_mw));
        chk("MemToReg_out", 32'(MemToReg_out), 32'(m_m2r));
        chk("zero_out", 32'(zero_out), 32'(m_zero));
    endtask

    task automatic instr(input logic [1:0] op, input logic [31:0] imm, input logic src,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic rw, input logic mr, input logic mw, input logic m2r);
        ALUOp_in = op; imm_in = imm; ALUSrc_in = src;
        rs_in = rs; rt_in = rt; rd_in = rd; rd1_in = a; rd2_in = b;
        RegWrite_in = rw; MemRead_in = mr; MemWrite_in = mw; MemToReg_in = m2r;
    endtask

    task automatic rand_instr();
        int          sel;
        logic [31:0] r;
        sel = $urandom_range(0, 9);
        r   = $urandom;
        rs_in = 5'($urandom_range(0, 7));
        rt_in = 5'($urandom_range(0, 7));
        rd_in = 5'($urandom_range(0, 7));
        rd1_in = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        rd2_in = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        RegWrite_in = 1'($urandom_range(0, 1));
        MemRead_in  = 1'($urandom_range(0, 1));
        MemWrite_in = 1'($urandom_range(0, 1));
        MemToReg_in = 1'($urandom_range(0, 1));
        ALUSrc_in   = 1'($urandom_range(0, 1));
        imm_in = r;
        if (sel <= 2) begin
            ALUOp_in = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
        end else if (sel <= 7) begin
            ALUOp_in = 2'b10;
            ALUSrc_in = 1'b0;
            imm_in = {r[31:6], functs[$urandom_range(0, 7)]};
        end else begin
            ALUOp_in = 2'b10;
            ALUSrc_in = 1'b0;
            RegWrite_in = 1'b1;
            imm_in = {r[31:6], 6'h18};
        end
    endtask

    int busy_cnt;
    int rw_pulses;

    initial begin
        // Reset state
        step();
        chk("reset alu_out", alu_out, 32'h0);
        chk("reset RegWrite_out", 32'(RegWrite_out), 32'h0);
        reset = 1'b0;

        // R-type add 5 + 7 -> $3
        instr(2'b10, 32'h20, 0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1, 0, 0, 0);
        step();
        chk("add alu_out", alu_out, 32'd12);
        chk("add dst_out", 32'(dst_out), 32'd3);
        chk("add RegWrite_out", 32'(RegWrite_out), 32'd1);
        chk("add zero_out", 32'(zero_out), 32'd0);
        chk("add ex_busy", 32'(dut_busy), 32'd0);

        // Forwarding priority: EX/MEM beats MEM/WB unless it is a load or targets $0
        instr(2'b00, 32'h10, 1, 5'd0, 5'd4, 5'd0, 32'd0, 32'd0, 1, 0, 0, 0);
        step();
        wb_RegWrite = 1; wb_rd = 5'd4; wb_data = 32'h99;
        instr(2'b01, 32'h0, 0, 5'd4, 5'd0, 5'd0, 32'd0, 32'd0, 1, 0, 0, 0);
        step();
        chk("fwd exmem", alu_out, 32'h10);
        wb_RegWrite = 0;
        instr(2'b00, 32'h10, 1, 5'd0, 5'd4, 5'd0, 32'd0, 32'd0, 1, 1, 0, 1);
        step();
        wb_RegWrite = 1;
        instr(2'b01, 32'h0, 0, 5'd4, 5'd0, 5'd0, 32'd0, 32'd0, 1, 0, 0, 0);
        step();
        chk("fwd memwb", alu_out, 32'h99);
        wb_RegWrite = 0;
        instr(2'b00, 32'h10, 1, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1, 0, 0, 0);
        step();
        wb_RegWrite = 1; wb_rd = 5'd0;
        instr(2'b01, 32'h0, 0, 5'd0, 5'd0, 5'd0, 32'd5, 32'd0, 1, 0, 0, 0);
        step();
        chk("fwd none r0", alu_out, 32'd5);
        wb_RegWrite = 0;

        // mul 0xFFFFFFFF * 3: 33 stall cycles, then the product
        instr(2'b10, 32'h18, 0, 5'd1, 5'd2, 5'd9, 32'hFFFF_FFFF, 32'd3, 1, 0, 0, 0);
        busy_cnt = 0; rw_pulses = 0;
        for (int i = 0; i < 33; i++) begin
            step();
            if (dut_busy) busy_cnt++;
            if (RegWrite_out) rw_pulses++;
        end
        step();
        chk("mul busy cycles", 32'(busy_cnt), 32'd33);
        chk("mul bubble RegWrite", 32'(rw_pulses), 32'd0);
        chk("mul alu_out", alu_out, 32'hFFFF_FFFD);
        chk("mul RegWrite_out", 32'(RegWrite_out), 32'd1);
        instr(2'b00, 32'h0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 0, 0, 0, 0);
        step();

        // Flush in cycle 10 of a multiply aborts it
        instr(2'b10, 32'h18, 0, 5'd1, 5'd2, 5'd9, 32'd7, 32'd6, 1, 0, 0, 0);
        rw_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (RegWrite_out) rw_pulses++;
        end
        flush = 1;
        step();
        flush = 0;
        instr(2'b00, 32'h0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 0, 0, 0, 0);
        step();
        chk("flush ex_busy", 32'(dut_busy), 32'd0);
        for (int i = 0; i < 30; i++) begin
            step();
            if (RegWrite_out) rw_pulses++;
        end
        chk("flush no RegWrite", 32'(rw_pulses), 32'd0);

        // slt, srl and a load address
        instr(2'b10, 32'h2A, 0, 5'd1, 5'd2, 5'd7, 32'hFFFF_FFFF, 32'd1, 1, 0, 0, 0);
        step();
        chk("slt", alu_out, 32'd1);
        instr(2'b10, 32'h7C2, 0, 5'd1, 5'd2, 5'd8, 32'd0, 32'h8000_0000, 1, 0, 0, 0);
        step();
        chk("srl", alu_out, 32'd1);
        instr(2'b00, 32'hFFFF_FFFC, 1, 5'd5, 5'd6, 5'd0, 32'h100, 32'd0, 1, 1, 0, 1);
        step();
        chk("lw alu_out", alu_out, 32'hFC);
        chk("lw dst_out", 32'(dst_out), 32'd6);
        chk("lw MemRead_out", 32'(MemRead_out), 32'd1);

        // Reset in the middle of a multiply, then a clean multiply
        instr(2'b10, 32'h18, 0, 5'd1, 5'd2, 5'd9, 32'd2, 32'd3, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step();
        reset = 1;
        step();
        chk("midmul reset alu_out", alu_out, 32'd0);
        chk("midmul reset RegWrite", 32'(RegWrite_out), 32'd0);
        reset = 0;
        instr(2'b00, 32'h0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 0, 0, 0, 0);
        step();
        chk("post reset ex_busy", 32'(dut_busy), 32'd0);
        instr(2'b10, 32'h18, 0, 5'd1, 5'd2, 5'd9, 32'd2, 32'd3, 1, 0, 0, 0);
        for (int i = 0; i < 34; i++) step();
        chk("mul after reset", alu_out, 32'd6);

        // Random traffic; the bench plays upstream and holds ID/EX while the model says busy
        for (int i = 0; i < 2000; i++) begin
            if (!(m_busy && !flush && !reset)) rand_instr();
            wb_RegWrite = 1'($urandom_range(0, 1));
            wb_rd       = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            flush       = ($urandom_range(0, 15) == 0);
            reset       = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
